// File: rtl/jcr_pkg.sv
// Shared definitions for the jacaranda PC/flag/interrupt sequencer.
// Default widths, the NONE level helper and the return-stack entry.
package jcr_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int NUM_IRQ_DEF = 4;

    // Stack entries are stored at these widths and sized down by the user.
    localparam int PC_MAX_W  = 32;
    localparam int LVL_MAX_W = 8;

    typedef struct packed {
        logic [PC_MAX_W-1:0]  pc;
        logic                 flag;
        logic [LVL_MAX_W-1:0] level;
    } stack_entry_t;

    // "No interrupt active" sits one past the lowest-priority line.
    function automatic int level_none(input int num_irq);
        return num_irq;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index 0 is the highest priority.
// Reports whether any line is set and the index of the winner.
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the lowest priority up so the lowest set index wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, condition flag and nested prioritised interrupt
// sequencer with a register-array return stack.
module pc_sequencer
    import jcr_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int NUM_IRQ     = NUM_IRQ_DEF,
    parameter int STACK_DEPTH = 4,
    parameter int VEC_STRIDE  = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             hold,
    input  logic                             jmp_en,
    input  logic                             je_en,
    input  logic                             ret,
    input  logic                             flag_w_en,
    input  logic                             alu_flag,
    input  logic [PC_W-1:0]                  target,
    input  logic [NUM_IRQ-1:0]               irq_req,
    input  logic [NUM_IRQ-1:0]               irq_en,
    input  logic [PC_W-1:0]                  vec_base,
    output logic [PC_W-1:0]                  pc,
    output logic                             flag,
    output logic                             in_isr,
    output logic [NUM_IRQ-1:0]               irq_ack,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             err_underflow
);

    localparam int LVL_W = $clog2(NUM_IRQ + 1);
    localparam int DEP_W = $clog2(STACK_DEPTH + 1);
    localparam int SP_W  = clog2_min1(STACK_DEPTH);

    localparam logic [LVL_W-1:0] LVL_NONE = LVL_W'(level_none(NUM_IRQ));
    localparam logic [DEP_W-1:0] DEP_FULL = DEP_W'(STACK_DEPTH);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic               flag_q, flag_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [DEP_W-1:0]   depth_q, depth_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;
    logic               err_q, err_d;

    stack_entry_t stack_q [STACK_DEPTH];

    logic [PC_W-1:0]  nxt_pc;
    logic             nxt_flag;
    logic             win_v;
    logic [LVL_W-1:0] win_idx;
    logic             take;
    logic [PC_W-1:0]  vec_pc;
    logic [SP_W-1:0]  push_idx;
    logic [SP_W-1:0]  pop_idx;
    logic             push_en;
    stack_entry_t     push_e;
    stack_entry_t     pop_e;
    logic             unused_pop_bits;

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (LVL_W)
    ) u_enc (
        .req_i   (irq_req & irq_en),
        .valid_o (win_v),
        .idx_o   (win_idx)
    );

    // Straight-line sequencing: jump, taken branch, or fall through.
    always_comb begin
        nxt_pc = pc_q + PC_W'(1);
        if (jmp_en || (je_en && flag_q)) begin
            nxt_pc = target;
        end
        nxt_flag = flag_q;
        if (je_en) begin
            nxt_flag = 1'b0;
        end else if (flag_w_en) begin
            nxt_flag = alu_flag;
        end
    end

    assign take = !hold && !ret && win_v
                  && (win_idx < lvl_q)
                  && (depth_q < DEP_FULL);

    assign vec_pc = vec_base
                    + PC_W'(VEC_STRIDE) * PC_W'(win_idx);

    assign push_idx = SP_W'(depth_q);
    assign pop_idx  = SP_W'(depth_q - DEP_W'(1));
    assign pop_e    = stack_q[pop_idx];

    // Only the low bits of a stored entry are meaningful here.
    assign unused_pop_bits = ^pop_e;

    // Next state: hold, return, interrupt entry or normal flow.
    always_comb begin
        pc_d    = pc_q;
        flag_d  = flag_q;
        lvl_d   = lvl_q;
        depth_d = depth_q;
        err_d   = err_q;
        ack_d   = '0;
        push_en = 1'b0;
        push_e  = '0;
        if (hold) begin
            ack_d = '0;
        end else if (ret && (depth_q != '0)) begin
            pc_d    = PC_W'(pop_e.pc);
            flag_d  = pop_e.flag;
            lvl_d   = LVL_W'(pop_e.level);
            depth_d = depth_q - DEP_W'(1);
        end else if (ret) begin
            pc_d  = pc_q + PC_W'(1);
            err_d = 1'b1;
        end else if (take) begin
            push_en      = 1'b1;
            push_e.pc    = PC_MAX_W'(nxt_pc);
            push_e.flag  = nxt_flag;
            push_e.level = LVL_MAX_W'(lvl_q);
            pc_d         = vec_pc;
            flag_d       = nxt_flag;
            lvl_d        = win_idx;
            depth_d      = depth_q + DEP_W'(1);
            ack_d        = NUM_IRQ'(1) << win_idx;
        end else begin
            pc_d   = nxt_pc;
            flag_d = nxt_flag;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            flag_q  <= 1'b0;
            lvl_q   <= LVL_NONE;
            depth_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flag_q  <= flag_d;
            lvl_q   <= lvl_d;
            depth_q <= depth_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Return stack: entry written at the current depth on entry.
    always_ff @(posedge clock) begin
        if (!reset && push_en) begin
            stack_q[push_idx] <= push_e;
        end
    end

    assign pc            = pc_q;
    assign flag          = flag_q;
    assign depth         = depth_q;
    assign in_isr        = (depth_q != '0);
    assign irq_ack       = ack_q;
    assign err_underflow = err_q;

endmodule
